// File: rtl/load_store_unit_if.sv
// Signal bundle between the core, load_store_unit and the word-wide data memory.
// slave = the LSU's view, master = the environment (core + memory) view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word core accesses onto a 32-bit word memory port.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two memory accesses.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | first (or only) memory word access in flight
// ACC1  | second word of a split access in flight
// DONE  | response cycle (error responses wait one cycle here first)
module load_store_unit (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave lsu_bus
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;

  function automatic logic [2:0] width_f(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: width_f = 3'd1;
      3'd1, 3'd5: width_f = 3'd2;
      default:    width_f = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [2:0] size, input logic [1:0] off,
                                      input logic upper);
    logic [6:0] lanes;
    case (width_f(size))
      3'd1:    lanes = 7'h01;
      3'd2:    lanes = 7'h03;
      default: lanes = 7'h0F;
    endcase
    lanes = lanes << off;
    be_f = upper ? {1'b0, lanes[6:4]} : lanes[3:0];
  endfunction

  function automatic logic [31:0] data_f(input logic [31:0] wdata, input logic [1:0] off,
                                         input logic upper);
    logic [55:0] placed;
    placed = {24'd0, wdata} << {off, 3'b000};
    data_f = upper ? {8'd0, placed[55:32]} : placed[31:0];
  endfunction

  function automatic logic [31:0] load_f(input logic [63:0] words, input logic [1:0] off,
                                         input logic [2:0] size);
    logic [31:0] sh;
    sh = 32'(words >> {off, 3'b000});
    case (size)
      3'd0:    load_f = {{24{sh[7]}}, sh[7:0]};
      3'd1:    load_f = {{16{sh[15]}}, sh[15:0]};
      3'd4:    load_f = {24'd0, sh[7:0]};
      3'd5:    load_f = {16'd0, sh[15:0]};
      default: load_f = sh;
    endcase
  endfunction

  logic [1:0]  in_off;
  logic [2:0]  in_size;
  logic [2:0]  in_width;
  logic        in_bad;
  logic [63:0] rd_words;
  logic [31:0] ld_val;

  assign in_off   = lsu_bus.req_addr[1:0];
  // Stores have no extension, so LBU/LHU stores collapse onto SB/SH.
  assign in_size  = (lsu_bus.req_we && (lsu_bus.req_size == 3'd4 || lsu_bus.req_size == 3'd5))
                    ? {1'b0, lsu_bus.req_size[1:0]} : lsu_bus.req_size;
  assign in_width = width_f(in_size);

`ifdef LSU_MISALIGNED_EN
  logic        split_q;
  logic [31:0] wdata_q;
  logic [31:0] word0_q;
  logic        in_split;

  assign in_split = ({1'b0, in_off} + in_width) > 3'd4;
  assign in_bad   = (lsu_bus.req_size == 3'd3) || (lsu_bus.req_size == 3'd6) ||
                    (lsu_bus.req_size == 3'd7);
  assign rd_words = (state_q == ACC1) ? {lsu_bus.mem_rdata, word0_q}
                                      : {32'd0, lsu_bus.mem_rdata};
`else
  assign in_bad   = (lsu_bus.req_size == 3'd3) || (lsu_bus.req_size == 3'd6) ||
                    (lsu_bus.req_size == 3'd7) ||
                    (in_width == 3'd2 && in_off[0]) || (in_width == 3'd4 && in_off != 2'd0);
  assign rd_words = {32'd0, lsu_bus.mem_rdata};
`endif

  assign ld_val = load_f(rd_words, off_q, size_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      size_q       <= 3'd0;
      off_q        <= 2'd0;
`ifdef LSU_MISALIGNED_EN
      split_q      <= 1'b0;
      wdata_q      <= 32'd0;
      word0_q      <= 32'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            size_q      <= in_size;
            off_q       <= in_off;
            if (in_bad) begin
              resp_err_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= lsu_bus.req_we;
              mem_addr_q  <= {lsu_bus.req_addr[31:2], 2'b00};
              mem_be_q    <= be_f(in_size, in_off, 1'b0);
              mem_wdata_q <= lsu_bus.req_we ? data_f(lsu_bus.req_wdata, in_off, 1'b0) : 32'd0;
`ifdef LSU_MISALIGNED_EN
              split_q     <= in_split;
              wdata_q     <= lsu_bus.req_wdata;
`endif
              state_q     <= ACC0;
            end
          end
        end
`ifdef LSU_MISALIGNED_EN
        ACC0, ACC1: begin
          if (lsu_bus.mem_ack && state_q == ACC0 && split_q) begin
            word0_q     <= lsu_bus.mem_rdata;
            mem_addr_q  <= mem_addr_q + 32'd4;
            mem_be_q    <= be_f(size_q, off_q, 1'b1);
            mem_wdata_q <= mem_we_q ? data_f(wdata_q, off_q, 1'b1) : 32'd0;
            state_q     <= ACC1;
          end else if (lsu_bus.mem_ack) begin
`else
        ACC0: begin
          if (lsu_bus.mem_ack) begin
`endif
            resp_rdata_q <= mem_we_q ? 32'd0 : ld_val;
            resp_valid_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            state_q      <= DONE;
          end
        end
        DONE: begin
          // Error responses arrive with resp_valid low and pulse it one cycle later.
          if (resp_valid_q) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end else begin
            resp_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_bus.req_ready  = req_ready_q;
  assign lsu_bus.resp_valid = resp_valid_q;
  assign lsu_bus.resp_rdata = resp_rdata_q;
  assign lsu_bus.resp_err   = resp_err_q;
  assign lsu_bus.mem_req    = mem_req_q;
  assign lsu_bus.mem_we     = mem_we_q;
  assign lsu_bus.mem_be     = mem_be_q;
  assign lsu_bus.mem_addr   = mem_addr_q;
  assign lsu_bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-array memory model predicts lanes, data,
// latency and load results; a second byte array acts as the real memory behind the port.
`timescale 1ns/1ps
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  load_store_unit_if bus();
  load_store_unit dut (.clk(clk), .rst_n(rst_n), .lsu_bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] phys_mem  [0:127];
  logic [7:0] model_mem [0:127];
  logic [2:0] sz_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd1, 3'd3, 3'd6, 3'd7};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int addr, input logic [31:0] val);
    for (int k = 0; k < 4; k++) begin
      phys_mem[addr + k]  = val[8*k +: 8];
      model_mem[addr + k] = val[8*k +: 8];
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] sz, input int a, input logic [31:0] wd,
                        input int maxd, output logic [31:0] rd, output logic er);
    int width, n_acc, acc, waited, d, s, exp_s, base;
    logic exp_err;
    logic [31:0] exp_rd, cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we, fresh, got_resp;
    logic [31:0] wa [2];
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];

    width   = (sz == 3'd0 || sz == 3'd4) ? 1 : (sz == 3'd1 || sz == 3'd5) ? 2 : 4;
    exp_err = (sz == 3'd3 || sz == 3'd6 || sz == 3'd7);
`ifndef LSU_MISALIGNED_EN
    if ((a % width) != 0) exp_err = 1'b1;
`endif
    n_acc  = 0;
    exp_rd = 32'd0;
    wa[0] = 0; wa[1] = 0; ebe[0] = 0; ebe[1] = 0; ewd[0] = 0; ewd[1] = 0;
    if (!exp_err) begin
      n_acc = ((a / 4) == ((a + width - 1) / 4)) ? 1 : 2;
      for (int j = 0; j < n_acc; j++) begin
        base  = (a / 4 + j) * 4;
        wa[j] = 32'(base);
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = base + k - a;
          if (idx >= 0 && idx < width) ebe[j][k] = 1'b1;
          if (idx >= 0 && idx < 4) ewd[j][8*k +: 8] = wd[8*idx +: 8];
        end
      end
      if (we) begin
        for (int i = 0; i < width; i++) model_mem[a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < width; i++) exp_rd[8*i +: 8] = model_mem[a + i];
        if (sz == 3'd0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
        if (sz == 3'd1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
      end
    end

    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = 32'(a);
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    acc = 0; fresh = 1'b1; waited = 0; d = 0; got_resp = 1'b0;
    cap_addr = 0; cap_wd = 0; cap_be = 0; cap_we = 0;
    exp_s = exp_err ? 2 : 1;
    for (s = 1; s <= 40; s++) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom();
      if (bus.resp_valid) begin
        got_resp = 1'b1;
        break;
      end
      if (bus.mem_req) begin
        if (fresh) begin
          check("access_expected", 32'(acc < n_acc), 32'd1);
          cap_addr = bus.mem_addr; cap_be = bus.mem_be; cap_we = bus.mem_we; cap_wd = bus.mem_wdata;
          if (acc < n_acc) begin
            check("mem_addr", bus.mem_addr, wa[acc]);
            check("mem_be", 32'(bus.mem_be), 32'(ebe[acc]));
            check("mem_we", 32'(bus.mem_we), 32'(we));
            if (we) check("mem_wdata", bus.mem_wdata, ewd[acc]);
          end
          d = $urandom_range(0, maxd);
          waited = 0;
          fresh = 1'b0;
        end else begin
          check("hold_addr", bus.mem_addr, cap_addr);
          check("hold_be", 32'(bus.mem_be), 32'(cap_be));
          check("hold_we", 32'(bus.mem_we), 32'(cap_we));
          check("hold_wdata", bus.mem_wdata, cap_wd);
        end
        if (waited == d) begin
          base = int'(bus.mem_addr[6:0]);
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = {phys_mem[base + 3], phys_mem[base + 2], phys_mem[base + 1], phys_mem[base]};
          if (bus.mem_we) begin
            for (int k = 0; k < 4; k++)
              if (bus.mem_be[k]) phys_mem[base + k] = bus.mem_wdata[8*k +: 8];
          end
          acc++;
          fresh = 1'b1;
          exp_s += d + 1;
        end else begin
          waited++;
        end
      end
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;

    check("resp_seen", 32'(got_resp), 32'd1);
    rd = 32'd0;
    er = 1'b0;
    if (got_resp) begin
      rd = bus.resp_rdata;
      er = bus.resp_err;
      check("resp_cycle", 32'(s), 32'(exp_s));
      check("access_count", 32'(acc), 32'(n_acc));
      check("resp_err", 32'(bus.resp_err), 32'(exp_err));
      check("resp_rdata", bus.resp_rdata, exp_rd);
      @(posedge clk); #1;
      check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
      check("req_ready_back", 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        any_resp, any_req;
    int          s;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_rdata = 32'd0; bus.mem_ack = 1'b0;
    for (int i = 0; i < 128; i++) begin
      phys_mem[i]  = 8'($urandom());
      model_mem[i] = phys_mem[i];
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_word(32'h10, 32'h8000_00F0);
    do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
    check("lw_aligned", rd, 32'h8000_00F0);

    set_word(32'h10, 32'h80AA_BBCC);
    do_req(1'b0, 3'd0, 32'h13, 32'd0, 0, rd, er);
    check("lb_sign", rd, 32'hFFFF_FF80);
    do_req(1'b0, 3'd4, 32'h13, 32'd0, 1, rd, er);
    check("lbu_zero", rd, 32'h0000_0080);

    do_req(1'b1, 3'd1, 32'h06, 32'h1234_ABCD, 0, rd, er);
    check("sh_rdata", rd, 32'd0);

    set_word(32'h08, 32'h4433_2211);
    set_word(32'h0C, 32'h8877_6655);
    do_req(1'b0, 3'd2, 32'h0B, 32'd0, 0, rd, er);
`ifdef LSU_MISALIGNED_EN
    check("lw_split_rdata", rd, 32'h7766_5544);
`else
    check("lw_misaligned_err", 32'(er), 32'd1);
`endif

    do_req(1'b0, 3'd3, 32'h20, 32'd0, 0, rd, er);
    check("size3_err", 32'(er), 32'd1);

    // Reset in the second wait cycle of a held-off LH.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 3'd1; bus.req_addr = 32'h20;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req_drop", 32'(bus.mem_req), 32'd0);
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    any_resp = 1'b0;
    any_req  = 1'b0;
    for (s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      any_resp |= bus.resp_valid;
      any_req  |= bus.mem_req;
    end
    check("rst_mid_no_resp", 32'(any_resp), 32'd0);
    check("rst_mid_no_req", 32'(any_req), 32'd0);

    for (int i = 0; i < 150; i++) begin
      do_req(1'($urandom_range(0, 1)), sz_tab[$urandom_range(0, 9)], $urandom_range(0, 123),
             $urandom(), 2, rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
